// File: rtl/scan_sched_16.sv
// scan_sched_16: scans a latched 16-bit word one bit per DIV-cycle slot.
// Define SCAN_SCHED_LOOP_EN for continuous scanning with a data_in reload at every frame end.
module scan_sched_16 #(
    parameter int unsigned DIV = 12500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] data_in,
    output logic        bit_out,
    output logic [3:0]  addr,
    output logic        tick,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [23:0] LP_LAST = 24'(DIV - 1);

    state_t      r_state;
    logic [23:0] r_cnt;
    logic [15:0] r_shadow;
    logic [3:0]  r_addr;
    logic        r_tick;
    logic        r_done;
    logic        r_busy;
    logic        w_wrap;

    assign w_wrap = (r_cnt == LP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 24'd0;
            r_shadow <= 16'd0;
            r_addr   <= 4'd0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // stop overrides start so a simultaneous request never launches a frame
                    if (start && !stop) begin
                        r_shadow <= data_in;
                        r_addr   <= 4'd0;
                        r_cnt    <= 24'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_addr  <= 4'd0;
                        r_cnt   <= 24'd0;
                        r_busy  <= 1'b0;
                    end else if (w_wrap) begin
                        r_cnt  <= 24'd0;
                        r_tick <= 1'b1;
                        r_addr <= r_addr + 4'd1;
                        if (r_addr == 4'd15) begin
                            r_done <= 1'b1;
`ifdef SCAN_SCHED_LOOP_EN
                            r_shadow <= data_in;
`else
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // bit_out is gated by busy so an idle block always drives 0
    assign bit_out = r_busy & r_shadow[r_addr];
    assign addr    = r_addr;
    assign tick    = r_tick;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_scan_sched_16.sv
// Bench for scan_sched_16 (DIV=4): elapsed-cycle reference model, directed scenarios and random traffic.
module tb_scan_sched_16;

    localparam int DIV   = 4;
    localparam int FRAME = 16 * DIV;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic        bit_out;
    logic [3:0]  addr;
    logic        tick;
    logic        busy;
    logic        done;

    scan_sched_16 #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .data_in (data_in),
        .bit_out (bit_out),
        .addr    (addr),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: a frame is just "cycles elapsed since start"
    bit          m_run    = 1'b0;
    int          m_el     = 0;
    logic [15:0] m_shadow = 16'd0;
    bit          m_tick   = 1'b0;
    bit          m_done   = 1'b0;
    logic [3:0]  e_addr;
    logic        e_bit;

    int busy_cnt = 0;
    int tick_cnt = 0;
    int done_cnt = 0;

    logic [0:0] exp_q[$];
    bit seq_029 [16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: advance the model with the inputs that were just sampled, then compare
    task automatic cyc();
        @(negedge clk);
        m_tick = 1'b0;
        m_done = 1'b0;
        if (!rst_n) begin
            m_run = 1'b0; m_el = 0; m_shadow = 16'd0;
        end else if (!m_run) begin
            if (start && !stop) begin
                m_run = 1'b1; m_el = 0; m_shadow = data_in;
            end
        end else if (stop) begin
            m_run = 1'b0; m_el = 0;
        end else begin
            m_el++;
            if (m_el % DIV == 0) m_tick = 1'b1;
            if (m_el == FRAME) begin
                m_done = 1'b1;
                m_el   = 0;
`ifdef SCAN_SCHED_LOOP_EN
                m_shadow = data_in;
`else
                m_run = 1'b0;
`endif
            end
        end
        e_addr = m_run ? 4'(m_el / DIV) : 4'd0;
        e_bit  = m_run ? m_shadow[e_addr] : 1'b0;
        chk("busy", 32'(busy), 32'(m_run));
        chk("addr", 32'(addr), 32'(e_addr));
        chk("bit_out", 32'(bit_out), 32'(e_bit));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("done", 32'(done), 32'(m_done));
        if (busy === 1'b1) busy_cnt++;
        if (tick === 1'b1) tick_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic wait_addr(input logic [3:0] a);
        int n = 0;
        while (!(busy === 1'b1 && addr == a) && n < 200) begin
            cyc();
            n++;
        end
        chk("wait_addr", 32'(busy === 1'b1 && addr == a), 32'd1);
    endtask

    task automatic pulse_start(input logic [15:0] d);
        data_in = d;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
    endtask

    initial begin
        int b0, t0, d0;
        logic sb;

        // reset
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_bit", 32'(bit_out), 32'd0);
        chk("rst_tick_done", 32'({tick, done}), 32'd0);
        rst_n = 1'b1;
        cyc();

        // full frame of A5C3, with data_in scrambled once the frame is latched
        foreach (seq_029[i]) exp_q.push_back(seq_029[i]);
        b0 = busy_cnt; t0 = tick_cnt; d0 = done_cnt;
        pulse_start(16'hA5C3);
        data_in = 16'(($urandom));
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < DIV; c++) begin
                if (c == 1) begin
                    sb = exp_q.pop_front();
                    chk("seq_bit", 32'(bit_out), 32'(sb));
                    chk("seq_addr", 32'(addr), 32'(s));
                end
                cyc();
            end
        end
        chk("frame_done", 32'(done), 32'd1);
        chk("frame_ticks", 32'(tick_cnt - t0), 32'd16);
        chk("frame_dones", 32'(done_cnt - d0), 32'd1);
`ifdef SCAN_SCHED_LOOP_EN
        chk("frame_busy_loop", 32'(busy), 32'd1);
`else
        chk("frame_busy_len", 32'(busy_cnt - b0), 32'(FRAME));
        chk("frame_busy_end", 32'(busy), 32'd0);
`endif
        cyc();
        chk("done_one_cycle", 32'(done), 32'd0);
        go_idle();

        // data_in changes mid-frame are invisible
        pulse_start(16'hA5C3);
        wait_addr(4'd5);
        data_in = 16'h0000;
        wait_addr(4'd8);
        chk("hold_bit8", 32'(bit_out), 32'd1);
        wait_addr(4'd9);
        chk("hold_bit9", 32'(bit_out), 32'd0);
        wait_addr(4'd10);
        chk("hold_bit10", 32'(bit_out), 32'd1);
        go_idle();

        // stop at addr 7
        d0 = done_cnt;
        pulse_start(16'hFFFF);
        wait_addr(4'd7);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_addr", 32'(addr), 32'd0);
        chk("stop_bit", 32'(bit_out), 32'd0);
        chk("stop_tick", 32'(tick), 32'd0);
        repeat (3 * DIV) cyc();
        chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
        chk("stop_stays_idle", 32'(busy), 32'd0);

        // stop coinciding with the final wrap
        pulse_start(16'(($urandom)));
        wait_addr(4'd15);
        repeat (DIV - 1) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("lastwrap_stop_done", 32'(done), 32'd0);
        chk("lastwrap_stop_tick", 32'(tick), 32'd0);
        chk("lastwrap_stop_busy", 32'(busy), 32'd0);
        cyc();

        // reset mid-frame, then a fresh frame starts from slot 0
        pulse_start(16'hFFFF);
        wait_addr(4'd9);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_outs", 32'({bit_out, addr, tick, busy, done}), 32'd0);
        pulse_start(16'h0001);
        chk("fresh_addr", 32'(addr), 32'd0);
        chk("fresh_busy", 32'(busy), 32'd1);
        chk("fresh_bit", 32'(bit_out), 32'd1);
        go_idle();

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", 32'(busy), 32'd0);
        cyc();

        // back-to-back frames: held start, or one start in loop mode
        d0 = done_cnt;
        start = 1'b1;
`ifdef SCAN_SCHED_LOOP_EN
        cyc();
        start = 1'b0;
        for (int i = 1; i < 3 * FRAME + 10; i++) begin
`else
        for (int i = 0; i < 3 * FRAME + 10; i++) begin
`endif
            data_in = 16'(($urandom));
            cyc();
        end
        start = 1'b0;
        chk("b2b_dones", 32'(done_cnt - d0), 32'd3);
        go_idle();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 79) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
            data_in = 16'(($urandom));
            cyc();
        end
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
